// File: rtl/axi_cmd_master_if.sv
// axi_cmd_master_if: command/response port plus AXI AW/W/B/AR/R channels of the single-outstanding master
interface axi_cmd_master_if #(parameter int ADDR_W = 32);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;
  logic [3:0]        cmd_wstrb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic [1:0]        rsp_resp;
  logic [3:0]        awid_o;
  logic [ADDR_W-1:0] awaddr_o;
  logic              awvalid_o;
  logic              awready_i;
  logic [31:0]       wdata_o;
  logic [3:0]        wstrb_o;
  logic              wlast_o;
  logic              wvalid_o;
  logic              wready_i;
  logic [1:0]        bresp_i;
  logic              bvalid_i;
  logic              bready_o;
  logic [3:0]        arid_o;
  logic [ADDR_W-1:0] araddr_o;
  logic              arvalid_o;
  logic              arready_i;
  logic [31:0]       rdata_i;
  logic [1:0]        rresp_i;
  logic              rvalid_i;
  logic              rready_o;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
           awready_i, wready_i, bresp_i, bvalid_i, arready_i, rdata_i, rresp_i, rvalid_i,
    output cmd_ready, rsp_valid, rsp_data, rsp_resp,
           awid_o, awaddr_o, awvalid_o, wdata_o, wstrb_o, wlast_o, wvalid_o, bready_o,
           arid_o, araddr_o, arvalid_o, rready_o
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
           awready_i, wready_i, bresp_i, bvalid_i, arready_i, rdata_i, rresp_i, rvalid_i,
    input  cmd_ready, rsp_valid, rsp_data, rsp_resp,
           awid_o, awaddr_o, awvalid_o, wdata_o, wstrb_o, wlast_o, wvalid_o, bready_o,
           arid_o, araddr_o, arvalid_o, rready_o
  );
endinterface

// File: rtl/axi_cmd_master.sv
// axi_cmd_master: single-outstanding AXI master turning one command into one AW/W/B or AR/R transaction
module axi_cmd_master #(
  parameter int         ADDR_W  = 32,
  parameter logic [3:0] ID      = 4'h0,
  parameter int         TIMEOUT = 256
) (
  input logic                clk,
  input logic                areset,
  axi_cmd_master_if.master   bus
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;
  localparam int WD_W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic [1:0]        rsp_resp_q, rsp_resp_d;
  logic              busy, final_hs, to_hit;
  assign busy     = (state_q != IDLE) && (state_q != RSP);
  assign final_hs = (state_q == WR_RESP && bus.bvalid_i) || (state_q == RD_RESP && bus.rvalid_i);
  assign to_hit   = (TIMEOUT != 0) && busy && (wd_q == WD_MAX) && !final_hs;
  // next-state: command capture, per-channel write completion, response capture, watchdog abort
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    rsp_data_d = rsp_data_q;
    rsp_resp_d = rsp_resp_q;
    wd_d       = busy ? wd_q + 1'b1 : '0;
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        addr_d    = bus.cmd_addr;
        wdata_d   = bus.cmd_wdata;
        wstrb_d   = bus.cmd_wstrb;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = bus.cmd_write ? WR_REQ : RD_REQ;
      end
      WR_REQ: begin
        aw_done_d = aw_done_q | bus.awready_i;
        w_done_d  = w_done_q | bus.wready_i;
        state_d   = (aw_done_d && w_done_d) ? WR_RESP : WR_REQ;
      end
      WR_RESP: if (bus.bvalid_i) begin
        rsp_resp_d = bus.bresp_i;
        rsp_data_d = '0;
        state_d    = RSP;
      end
      RD_REQ: state_d = bus.arready_i ? RD_RESP : RD_REQ;
      RD_RESP: if (bus.rvalid_i) begin
        rsp_resp_d = bus.rresp_i;
        rsp_data_d = bus.rdata_i;
        state_d    = RSP;
      end
      RSP: state_d = bus.rsp_ready ? IDLE : RSP;
      default: state_d = IDLE;
    endcase
    if (to_hit) begin
      state_d    = RSP;
      rsp_resp_d = 2'b11;
      rsp_data_d = '0;
    end
  end
  // state and datapath registers, cleared asynchronously so outputs drop mid-transaction
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      wd_q       <= '0;
      rsp_data_q <= '0;
      rsp_resp_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      wd_q       <= wd_d;
      rsp_data_q <= rsp_data_d;
      rsp_resp_q <= rsp_resp_d;
    end
  end
  assign bus.cmd_ready = (state_q == IDLE) && !areset;
  assign bus.rsp_valid = state_q == RSP;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_resp  = rsp_resp_q;
  assign bus.awid_o    = ID;
  assign bus.awaddr_o  = addr_q;
  assign bus.awvalid_o = (state_q == WR_REQ) && !aw_done_q;
  assign bus.wdata_o   = wdata_q;
  assign bus.wstrb_o   = wstrb_q;
  assign bus.wlast_o   = 1'b1;
  assign bus.wvalid_o  = (state_q == WR_REQ) && !w_done_q;
  assign bus.bready_o  = state_q == WR_RESP;
  assign bus.arid_o    = ID;
  assign bus.araddr_o  = addr_q;
  assign bus.arvalid_o = state_q == RD_REQ;
  assign bus.rready_o  = state_q == RD_RESP;
endmodule

// File: tb/tb_axi_cmd_master.sv
// tb_axi_cmd_master: directed checks of write, stalled write, read, watchdog timeout and mid-read reset
module tb_axi_cmd_master;
  logic clk = 1'b0;
  logic areset;
  int   vectors = 0;
  int   errs = 0;
  axi_cmd_master_if #(.ADDR_W(32)) bus ();
  axi_cmd_master #(.ADDR_W(32), .ID(4'h5), .TIMEOUT(8)) dut (.clk(clk), .areset(areset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic cmd(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_wstrb = s;
    cyc();
    bus.cmd_valid = 1'b0;
  endtask
  initial begin
    int n;
    areset = 1'b1;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0; bus.cmd_wstrb = 0;
    bus.rsp_ready = 0; bus.awready_i = 0; bus.wready_i = 0; bus.bresp_i = 0; bus.bvalid_i = 0;
    bus.arready_i = 0; bus.rdata_i = 0; bus.rresp_i = 0; bus.rvalid_i = 0;
    #1;
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_awvalid", bus.awvalid_o, 0);
    chk("rst_wlast", bus.wlast_o, 1);
    chk("rst_awid", bus.awid_o, 4'h5);
    chk("rst_arid", bus.arid_o, 4'h5);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    cyc(); cyc();
    areset = 1'b0;
    #1;
    chk("rel_cmd_ready", bus.cmd_ready, 1);
    // plain write, all readies high
    bus.awready_i = 1; bus.wready_i = 1; bus.arready_i = 1;
    cmd(1, 32'h8, 32'hDEADBEEF, 4'hF);
    chk("w1_awvalid", bus.awvalid_o, 1);
    chk("w1_wvalid", bus.wvalid_o, 1);
    chk("w1_awaddr", bus.awaddr_o, 32'h8);
    chk("w1_wdata", bus.wdata_o, 32'hDEADBEEF);
    chk("w1_wstrb", bus.wstrb_o, 4'hF);
    chk("w1_cmd_ready", bus.cmd_ready, 0);
    bus.bvalid_i = 1; bus.bresp_i = 2'b00;
    cyc();
    chk("w1_bready", bus.bready_o, 1);
    chk("w1_awvalid_drop", bus.awvalid_o, 0);
    cyc();
    bus.bvalid_i = 0;
    chk("w1_rsp_valid", bus.rsp_valid, 1);
    chk("w1_rsp_resp", bus.rsp_resp, 0);
    chk("w1_rsp_data", bus.rsp_data, 0);
    chk("w1_bready_off", bus.bready_o, 0);
    bus.rsp_ready = 1;
    cyc();
    bus.rsp_ready = 0;
    chk("w1_idle", bus.cmd_ready, 1);
    chk("w1_rsp_drop", bus.rsp_valid, 0);
    // write with W accepted four cycles after AW
    bus.wready_i = 0;
    cmd(1, 32'h20, 32'hCAFEF00D, 4'h3);
    chk("w2_both_valid", {bus.awvalid_o, bus.wvalid_o}, 2'b11);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("w2_awvalid_low", bus.awvalid_o, 0);
      chk("w2_wvalid_held", bus.wvalid_o, 1);
      chk("w2_wdata_stable", {bus.wdata_o, bus.wstrb_o}, {32'hCAFEF00D, 4'h3});
      chk("w2_no_bready", bus.bready_o, 0);
    end
    bus.wready_i = 1;
    cyc();
    chk("w2_wvalid_drop", bus.wvalid_o, 0);
    chk("w2_bready", bus.bready_o, 1);
    bus.bvalid_i = 1; bus.bresp_i = 2'b01;
    cyc();
    bus.bvalid_i = 0;
    chk("w2_rsp", {bus.rsp_valid, bus.rsp_resp, bus.rsp_data}, {1'b1, 2'b01, 32'h0});
    bus.rsp_ready = 1;
    cyc();
    bus.rsp_ready = 0;
    // read with SLVERR, response held under backpressure
    cmd(0, 32'h4, 32'h0, 4'h0);
    chk("r1_arvalid", bus.arvalid_o, 1);
    chk("r1_araddr", bus.araddr_o, 32'h4);
    chk("r1_no_awvalid", bus.awvalid_o, 0);
    cyc();
    chk("r1_rready", bus.rready_o, 1);
    chk("r1_arvalid_drop", bus.arvalid_o, 0);
    bus.rvalid_i = 1; bus.rdata_i = 32'h12345678; bus.rresp_i = 2'b10;
    cyc();
    bus.rvalid_i = 0; bus.rdata_i = 32'hFFFFFFFF; bus.rresp_i = 2'b00;
    for (int i = 0; i < 5; i++) begin
      chk("r1_rsp_held", {bus.rsp_valid, bus.rsp_resp, bus.rsp_data}, {1'b1, 2'b10, 32'h12345678});
      cyc();
    end
    chk("r1_rsp_still", bus.rsp_valid, 1);
    bus.rsp_ready = 1;
    cyc();
    bus.rsp_ready = 0;
    chk("r1_idle", {bus.cmd_ready, bus.rsp_valid}, 2'b10);
    // write whose B never arrives: watchdog of 8 busy cycles
    cmd(1, 32'hC, 32'h11112222, 4'hF);
    n = 1;
    while (!bus.rsp_valid && n < 20) begin
      cyc();
      n++;
    end
    chk("to_latency_ok", (n >= 9 && n <= 10), 1);
    chk("to_rsp", {bus.rsp_valid, bus.rsp_resp, bus.rsp_data}, {1'b1, 2'b11, 32'h0});
    chk("to_bready_low", bus.bready_o, 0);
    bus.bvalid_i = 1; bus.bresp_i = 2'b00;
    bus.rsp_ready = 1;
    cyc();
    bus.rsp_ready = 0;
    chk("to_late_b_ignored", {bus.bready_o, bus.rsp_valid, bus.cmd_ready}, 3'b001);
    cyc();
    bus.bvalid_i = 0;
    chk("to_still_idle", bus.cmd_ready, 1);
    cmd(0, 32'h10, 32'h0, 4'h0);
    cyc();
    bus.rvalid_i = 1; bus.rdata_i = 32'hAABBCCDD; bus.rresp_i = 2'b00;
    cyc();
    bus.rvalid_i = 0;
    chk("to_next_read", {bus.rsp_valid, bus.rsp_resp, bus.rsp_data}, {1'b1, 2'b00, 32'hAABBCCDD});
    bus.rsp_ready = 1;
    cyc();
    bus.rsp_ready = 0;
    // asynchronous reset while waiting for R
    cmd(0, 32'h18, 32'h0, 4'h0);
    cyc();
    chk("ar_in_rresp", bus.rready_o, 1);
    #2 areset = 1'b1;
    #1;
    chk("ar_rready", bus.rready_o, 0);
    chk("ar_cmd_ready", bus.cmd_ready, 0);
    chk("ar_valids", {bus.arvalid_o, bus.awvalid_o, bus.wvalid_o, bus.bready_o, bus.rsp_valid}, 5'b0);
    chk("ar_araddr", bus.araddr_o, 32'h0);
    cyc();
    areset = 1'b0;
    #1;
    chk("ar_release", bus.cmd_ready, 1);
    cmd(0, 32'h4, 32'h0, 4'h0);
    chk("ar2_araddr", {bus.arvalid_o, bus.araddr_o}, {1'b1, 32'h4});
    cyc();
    bus.rvalid_i = 1; bus.rdata_i = 32'h0BADF00D; bus.rresp_i = 2'b00;
    cyc();
    bus.rvalid_i = 0;
    chk("ar2_rsp", {bus.rsp_valid, bus.rsp_resp, bus.rsp_data}, {1'b1, 2'b00, 32'h0BADF00D});
    bus.rsp_ready = 1;
    cyc();
    bus.rsp_ready = 0;
    chk("ar2_idle", bus.cmd_ready, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
